// File: rtl/mpu_matrix_buffer_pkg.sv
// Shared definitions for the MPU matrix staging buffer.
// Provides the buffer FSM state type, the default floating-point word width
// and a small dimension range helper.
package global_defs;

   // IEEE-754 double precision word width, default element width of the buffer.
   localparam int FP_WIDTH = 64;

   // Buffer controller states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } mpu_buf_state_t;

   // True when a requested run-time dimension lies in 1..max_dim.
   function automatic logic dim_in_range(input int unsigned dim, input int unsigned max_dim);
      return (dim >= 1) && (dim <= max_dim);
   endfunction

endpackage

// File: rtl/mpu_matrix_buffer_index_counter.sv
// mpu_index_counter: (row, col) walker over a run-time sized matrix.
// Either the column (row-major walk) or the row (column-major walk) is the
// inner dimension. The counter also exposes the position it will move to on
// the next enable so the caller can prefetch the following element, and a
// flag marking the final element; stepping past it wraps back to (0,0).
module mpu_index_counter #(
   parameter int ROW_W   = 2,
   parameter int COL_W   = 2,
   parameter int LIM_R_W = 3,
   parameter int LIM_C_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               en_i,
   input  logic               row_inner_i,
   input  logic [LIM_R_W-1:0] lim_rows_i,
   input  logic [LIM_C_W-1:0] lim_cols_i,
   output logic [ROW_W-1:0]   row_o,
   output logic [COL_W-1:0]   col_o,
   output logic [ROW_W-1:0]   next_row_o,
   output logic [COL_W-1:0]   next_col_o,
   output logic               last_o
);

   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] step_row;
   logic [COL_W-1:0] step_col;
   logic             row_end;
   logic             col_end;

   assign row_end = (LIM_R_W'(row_q) == (lim_rows_i - LIM_R_W'(1)));
   assign col_end = (LIM_C_W'(col_q) == (lim_cols_i - LIM_C_W'(1)));
   assign last_o  = row_end && col_end;

   // Position following the current one in the selected walk order.
   always_comb begin
      step_row = row_q;
      step_col = col_q;
      if (last_o) begin
         step_row = '0;
         step_col = '0;
      end else if (row_inner_i) begin
         if (row_end) begin
            step_row = '0;
            step_col = col_q + COL_W'(1);
         end else begin
            step_row = row_q + ROW_W'(1);
         end
      end else begin
         if (col_end) begin
            step_col = '0;
            step_row = row_q + ROW_W'(1);
         end else begin
            step_col = col_q + COL_W'(1);
         end
      end
   end

   // Clear has priority over stepping so a new operation always starts at (0,0).
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (en_i) begin
         row_d = step_row;
         col_d = step_col;
      end
   end

   // Index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_o      = row_q;
   assign col_o      = col_q;
   assign next_row_o = step_row;
   assign next_col_o = step_col;

endmodule

// File: rtl/mpu_matrix_buffer.sv
// mpu_matrix_buffer: staging buffer between the memory side and the FPU array.
// A matrix of up to MAX_M x MAX_N words is loaded serially in row-major order,
// held, and streamed back out under consumer backpressure as often as needed.
// Optional feature macro: MPU_TRANSPOSE_EN -- when defined, store_transpose_i
// (sampled with store_req_i) selects a column-major readout for that store.
module mpu_matrix_buffer
   import global_defs::*;
#(
   parameter int DATA_WIDTH = FP_WIDTH,
   parameter int MAX_M      = 4,
   parameter int MAX_N      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_req_i,
   input  logic [$clog2(MAX_M+1)-1:0]   dim_m_i,
   input  logic [$clog2(MAX_N+1)-1:0]   dim_n_i,
   input  logic                         load_valid_i,
   input  logic [DATA_WIDTH-1:0]        load_data_i,
   output logic                         load_ready_o,
   output logic                         load_done_o,
   input  logic                         store_req_i,
   input  logic                         store_transpose_i,
   output logic                         store_valid_o,
   output logic [DATA_WIDTH-1:0]        store_data_o,
   input  logic                         store_ready_i,
   output logic                         store_done_o,
   output logic                         busy_o,
   output logic                         err_o
);

   localparam int MW    = $clog2(MAX_M + 1);
   localparam int NW    = $clog2(MAX_N + 1);
   localparam int ROW_W = (MAX_M > 1) ? $clog2(MAX_M) : 1;
   localparam int COL_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

   mpu_buf_state_t state_q, state_d;

   logic                  matrix_valid_q, matrix_valid_d;
   logic [MW-1:0]         dim_m_q, dim_m_d;
   logic [NW-1:0]         dim_n_q, dim_n_d;
   logic                  store_valid_q, store_valid_d;
   logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
   logic                  load_done_q, load_done_d;
   logic                  store_done_q, store_done_d;
   logic                  err_q, err_d;

   logic [DATA_WIDTH-1:0] mem_q [MAX_M][MAX_N];
   logic                  mem_we;

   logic                  dims_ok;
   logic                  load_accept;
   logic                  store_accept;

   logic                  cnt_clear;
   logic                  cnt_en;
   logic                  cnt_row_inner;
   logic [ROW_W-1:0]      cnt_row;
   logic [COL_W-1:0]      cnt_col;
   logic [ROW_W-1:0]      cnt_next_row;
   logic [COL_W-1:0]      cnt_next_col;
   logic                  cnt_last;

   assign dims_ok      = dim_in_range(32'(dim_m_i), MAX_M) && dim_in_range(32'(dim_n_i), MAX_N);
   // A load request always wins over a simultaneous store request.
   assign load_accept  = (state_q == IDLE) && load_req_i && dims_ok;
   assign store_accept = (state_q == IDLE) && !load_req_i && store_req_i && matrix_valid_q;

`ifdef MPU_TRANSPOSE_EN
   logic transpose_q, transpose_d;

   // Readout order is captured with the store request and held for that store.
   always_comb begin
      transpose_d = transpose_q;
      if (store_accept) begin
         transpose_d = store_transpose_i;
      end
   end

   // Transpose mode register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         transpose_q <= 1'b0;
      end else begin
         transpose_q <= transpose_d;
      end
   end

   // Loads are always row-major; only a store may walk rows innermost.
   assign cnt_row_inner = (state_q == STORE) && transpose_q;
`else
   logic unused_transpose;
   assign unused_transpose = store_transpose_i;
   assign cnt_row_inner    = 1'b0;
`endif

   mpu_index_counter #(
      .ROW_W   (ROW_W),
      .COL_W   (COL_W),
      .LIM_R_W (MW),
      .LIM_C_W (NW)
   ) u_index_counter (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (cnt_clear),
      .en_i        (cnt_en),
      .row_inner_i (cnt_row_inner),
      .lim_rows_i  (dim_m_q),
      .lim_cols_i  (dim_n_q),
      .row_o       (cnt_row),
      .col_o       (cnt_col),
      .next_row_o  (cnt_next_row),
      .next_col_o  (cnt_next_col),
      .last_o      (cnt_last)
   );

   // Controller: request arbitration, load sequencing and store streaming.
   always_comb begin
      state_d        = state_q;
      matrix_valid_d = matrix_valid_q;
      dim_m_d        = dim_m_q;
      dim_n_d        = dim_n_q;
      store_valid_d  = store_valid_q;
      store_data_d   = store_data_q;
      load_done_d    = 1'b0;
      store_done_d   = 1'b0;
      err_d          = 1'b0;
      mem_we         = 1'b0;
      cnt_clear      = 1'b0;
      cnt_en         = 1'b0;

      case (state_q)
         IDLE: begin
            if (load_req_i) begin
               if (load_accept) begin
                  dim_m_d        = dim_m_i;
                  dim_n_d        = dim_n_i;
                  matrix_valid_d = 1'b0;
                  cnt_clear      = 1'b1;
                  state_d        = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (store_req_i) begin
               if (store_accept) begin
                  // First element is (0,0) in either walk order.
                  store_valid_d = 1'b1;
                  store_data_d  = mem_q[0][0];
                  cnt_clear     = 1'b1;
                  state_d       = STORE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         LOAD: begin
            if (load_valid_i) begin
               mem_we = 1'b1;
               cnt_en = 1'b1;
               if (cnt_last) begin
                  matrix_valid_d = 1'b1;
                  load_done_d    = 1'b1;
                  state_d        = IDLE;
               end
            end
         end

         STORE: begin
            if (store_valid_q && store_ready_i) begin
               cnt_en = 1'b1;
               if (cnt_last) begin
                  store_valid_d = 1'b0;
                  store_done_d  = 1'b1;
                  state_d       = IDLE;
               end else begin
                  // Present the next element straight away so a ready
                  // consumer sees one word per cycle.
                  store_data_d = mem_q[cnt_next_row][cnt_next_col];
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         matrix_valid_q <= 1'b0;
         dim_m_q        <= '0;
         dim_n_q        <= '0;
         store_valid_q  <= 1'b0;
         store_data_q   <= '0;
         load_done_q    <= 1'b0;
         store_done_q   <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         matrix_valid_q <= matrix_valid_d;
         dim_m_q        <= dim_m_d;
         dim_n_q        <= dim_n_d;
         store_valid_q  <= store_valid_d;
         store_data_q   <= store_data_d;
         load_done_q    <= load_done_d;
         store_done_q   <= store_done_d;
         err_q          <= err_d;
      end
   end

   // Element storage: each word is written when the load walker points at it.
   for (genvar gi = 0; gi < MAX_M; gi++) begin : g_row
      for (genvar gj = 0; gj < MAX_N; gj++) begin : g_col
         // Storage word (gi, gj), cleared on reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_q[gi][gj] <= '0;
            end else if (mem_we && (cnt_row == ROW_W'(gi)) && (cnt_col == COL_W'(gj))) begin
               mem_q[gi][gj] <= load_data_i;
            end
         end
      end
   end

   assign load_ready_o  = (state_q == LOAD);
   assign busy_o        = (state_q != IDLE);
   assign load_done_o   = load_done_q;
   assign store_valid_o = store_valid_q;
   assign store_data_o  = store_data_q;
   assign store_done_o  = store_done_q;
   assign err_o         = err_q;

endmodule

// File: doc/mpu_matrix_buffer.md
# mpu_matrix_buffer

Parametrised matrix staging buffer for the MPU: loads an M×N matrix of floating-point words serially, holds it, and streams it back out under backpressure. It replaces the separate fixed-size load and store paths with one unit that has run-time dimensions and an optional transposed readout. It sits between the memory/testbench interface and the FPU multiplier/adder array.

## Interface
- DATA_WIDTH, 64: element width in bits (IEEE-754 double).
- MAX_M, 4: maximum rows.
- MAX_N, 4: maximum columns.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_req_i  input  1  start a load when IDLE.
- dim_m_i  input  $clog2(MAX_M+1)  rows, sampled with load_req_i.
- dim_n_i  input  $clog2(MAX_N+1)  columns, sampled with load_req_i.
- load_valid_i  input  1  load_data_i holds a valid element.
- load_data_i  input  DATA_WIDTH  element, row-major order.
- load_ready_o  output  1  buffer accepts an element this cycle.
- load_done_o  output  1  one-cycle pulse, load complete.
- store_req_i  input  1  start streaming the held matrix when IDLE.
- store_transpose_i  input  1  stream column-major (MPU_TRANSPOSE_EN only).
- store_valid_o  output  1  store_data_o valid.
- store_data_o  output  DATA_WIDTH  streamed element.
- store_ready_i  input  1  consumer accepts element.
- store_done_o  output  1  one-cycle pulse, last element accepted.
- busy_o  output  1  state is not IDLE.
- err_o  output  1  one-cycle pulse, request rejected.

## Operation
- States: IDLE, LOAD, STORE. Held flag matrix_valid plus registered dims m, n.
- IDLE + load_req_i: if 1≤dim_m_i≤MAX_M and 1≤dim_n_i≤MAX_N, latch dims, clear matrix_valid, go LOAD; else err_o pulse, stay IDLE, matrix_valid unchanged.
- IDLE + store_req_i (no load_req_i): if matrix_valid go STORE; else err_o pulse.
- load_req_i and store_req_i together in IDLE: load wins, store ignored (no error).
- Requests outside IDLE are ignored.
- LOAD: load_ready_o=1; each cycle with load_valid_i writes element (r,c), c increments, wraps to 0 with r+1 at c=n-1. On element (m-1,n-1): next state IDLE, load_done_o pulse, matrix_valid=1.
- STORE: streams (r,c) row-major; transposed mode iterates r innermost (column-major). Advance on store_valid_o && store_ready_i. After last handshake: IDLE, store_done_o pulse. matrix_valid stays 1; repeat stores allowed.
- Reset (any time, incl. mid-LOAD/STORE): state IDLE, matrix_valid=0, indices 0, storage cleared to 0.

## Timing
- Reset value of every output: 0.
- load_ready_o combinational from state; element captured same edge as handshake; load_done_o asserted the cycle after the last element handshake; busy_o falls same cycle.
- store_data_o/store_valid_o registered: first element valid the cycle after store_req_i is accepted; held stable while store_ready_i=0; with ready held high, one element per cycle, m·n cycles total.
- store_done_o asserted the cycle after the last handshake; store_valid_o low that cycle.
- err_o asserted the cycle after the rejected request.
- No zero-bubble back-to-back: a new request is accepted no earlier than the cycle done is high.

## Configuration
- MPU_TRANSPOSE_EN defined: store_transpose_i sampled with store_req_i, selects column-major streaming for that store.
- Not defined: store_transpose_i ignored, always row-major; transpose index logic not synthesised.

## Structure
- global_defs holds: mpu_buf_state_t enum {IDLE, LOAD, STORE}, FP_WIDTH constant (64) used as DATA_WIDTH default.
- Storage: MAX_M×MAX_N register array inside the block.
- One sub-module: mpu_index_counter — (row, col) counter with run-time limits, enable, clear, and inner-dimension select (row-inner vs col-inner), emitting last-element flag.

## Test plan
- Load 2×3 with 1.0..6.0 (0x3FF0000000000000…0x4018000000000000), store with ready=1 -> 6 elements in order 1..6 on consecutive cycles, store_done_o on cycle 7.
- Same store with store_ready_i toggled 1,0,0,1… -> data held stable during stalls, no element dropped or duplicated.
- MPU_TRANSPOSE_EN, 2×3, transpose=1 -> order 1,4,2,5,3,6.
- load_req_i with dims 0×3 and 5×1 -> err_o pulse each, busy_o stays 0; store_req_i after reset -> err_o.
- rst asserted after 3 of 6 load elements -> all outputs 0, subsequent store_req_i -> err_o.
- load_req_i and store_req_i same cycle with valid matrix held -> LOAD entered, no err_o, old matrix invalidated.
